// File: rtl/basic_homework4_pkg.sv
// Shared defaults for the basic_homework4 priority encoder.
// Other widths are reached by overriding the module parameters.
package basic_homework4_pkg;

    localparam int N_IN_DEF = 8;
    localparam int Y_W_DEF  = 3;

    typedef logic [Y_W_DEF-1:0] idx_t;

endpackage

// File: rtl/basic_homework4_prio_enc.sv
// Combinational highest-index-wins priority encoder with enable.
// No path from in_vec to the outputs when en is low, so X on in_vec stays contained.
module prio_enc
    import basic_homework4_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int Y_W  = Y_W_DEF
) (
    input  logic [N_IN-1:0] in_vec,
    input  logic            en,
    output logic [Y_W-1:0]  idx,
    output logic            valid
);

    // Scan from the MSB down; the first set bit seen claims the index.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        if (en) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (in_vec[i] && !valid) begin
                    idx   = Y_W'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/basic_homework4.sv
// Registered priority encoder: Y is the highest asserted IN index, Done marks a real index.
// One cycle latency; the only state is the output register.
module basic_homework4
    import basic_homework4_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int Y_W  = Y_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] IN,
    input  logic            EN,
    output logic [Y_W-1:0]  Y,
    output logic            Done
);

    logic [Y_W-1:0] next_idx;
    logic           next_valid;

    prio_enc #(
        .N_IN (N_IN),
        .Y_W  (Y_W)
    ) u_prio_enc (
        .in_vec (IN),
        .en     (EN),
        .idx    (next_idx),
        .valid  (next_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y    <= '0;
            Done <= 1'b0;
        end else begin
            Y    <= next_idx;
            Done <= next_valid;
        end
    end

endmodule

// File: tb/tb_basic_homework4.sv
// Self-checking bench for basic_homework4 at N_IN=8 and N_IN=16.
module tb_basic_homework4;
    import basic_homework4_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in8;
    logic        en8;
    idx_t        y8;
    logic        done8;
    logic [15:0] in16;
    logic        en16;
    logic [3:0]  y16;
    logic        done16;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard: expected {Done, Y} for each instance
    logic [3:0] exp_q[$];
    logic [4:0] exp16_q[$];

    typedef struct {
        logic [7:0] in_v;
        logic       en;
        logic [2:0] y;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    basic_homework4 dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (in8),
        .EN    (en8),
        .Y     (y8),
        .Done  (done8)
    );

    basic_homework4 #(.N_IN(16), .Y_W(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (in16),
        .EN    (en16),
        .Y     (y16),
        .Done  (done16)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: floor(log2(v)) for the highest set bit, -1 when no request
    function automatic int ref_msb(input logic [63:0] v, input logic e);
        logic [64:0] w;
        if (!e || v == 64'd0) return -1;
        w = {1'b0, v} + 65'd1;
        return $clog2(w) - 1;
    endfunction

    function automatic logic [3:0] ref8(input logic [7:0] v, input logic e);
        int m = ref_msb({56'd0, v}, e);
        return (m < 0) ? 4'h0 : {1'b1, 3'(m)};
    endfunction

    function automatic logic [4:0] ref16(input logic [15:0] v, input logic e);
        int m = ref_msb({48'd0, v}, e);
        return (m < 0) ? 5'h0 : {1'b1, 4'(m)};
    endfunction

    // driver
    task automatic drive(input logic [7:0] a, input logic ea, input logic [15:0] b, input logic eb);
        in8  = a;
        en8  = ea;
        in16 = b;
        en16 = eb;
        exp_q.push_back(ref8(a, ea));
        exp16_q.push_back(ref16(b, eb));
    endtask

    task automatic check_sb(input string tag);
        logic [3:0] e8;
        logic [4:0] e16;
        if (exp_q.size() == 0 || exp16_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e8  = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        check({tag, "_y8"}, {61'd0, y8}, {61'd0, e8[2:0]});
        check({tag, "_done8"}, {63'd0, done8}, {63'd0, e8[3]});
        check({tag, "_y16"}, {60'd0, y16}, {60'd0, e16[3:0]});
        check({tag, "_done16"}, {63'd0, done16}, {63'd0, e16[4]});
    endtask

    initial begin
        vec_t v;

        // reset held with full request: outputs zero before any edge
        rst_n = 1'b0;
        in8   = 8'hFF;
        en8   = 1'b1;
        in16  = 16'hFFFF;
        en16  = 1'b1;
        #2;
        check("reset_y", {61'd0, y8}, 64'd0);
        check("reset_done", {63'd0, done8}, 64'd0);
        tick();
        check("reset_edge_done", {63'd0, done8}, 64'd0);
        check("reset_edge_done16", {63'd0, done16}, 64'd0);
        rst_n = 1'b1;

        // directed table
        tbl.push_back('{8'h80, 1'b0, 3'd0, 1'b0});
        for (int i = 0; i <= 8; i++) begin
            v.in_v = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
            v.en   = 1'b1;
            v.y    = (i == 0) ? 3'd0 : 3'(i - 1);
            v.done = (i != 0);
            tbl.push_back(v);
        end
        tbl.push_back('{8'b0010_0101, 1'b1, 3'd5, 1'b1});
        tbl.push_back('{8'hFF, 1'b1, 3'd7, 1'b1});
        tbl.push_back('{8'hFF, 1'b0, 3'd0, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 3'd0, 1'b1});

        for (int k = 0; k < tbl.size(); k++) begin
            in8 = tbl[k].in_v;
            en8 = tbl[k].en;
            tick();
            check($sformatf("tbl%0d_y", k), {61'd0, y8}, {61'd0, tbl[k].y});
            check($sformatf("tbl%0d_done", k), {63'd0, done8}, {63'd0, tbl[k].done});
        end

        // X on IN while disabled must not reach the outputs
        in8 = 'x;
        en8 = 1'b0;
        tick();
        check("x_dis_y", {61'd0, y8}, 64'd0);
        check("x_dis_done", {63'd0, done8}, 64'd0);

        // wide instance
        in16 = 16'h8001;
        en16 = 1'b1;
        tick();
        check("w16_y", {60'd0, y16}, 64'd15);
        check("w16_done", {63'd0, done16}, 64'd1);
        in16 = 16'h0001;
        tick();
        check("w16_lsb_y", {60'd0, y16}, 64'd0);
        check("w16_lsb_done", {63'd0, done16}, 64'd1);

        // reset mid-run: clears at once, resumes on first edge after release
        in8 = 8'h40;
        en8 = 1'b1;
        tick();
        check("mid_pre_y", {61'd0, y8}, 64'd6);
        check("mid_pre_done", {63'd0, done8}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_y", {61'd0, y8}, 64'd0);
        check("mid_rst_done", {63'd0, done8}, 64'd0);
        check("mid_rst_y16", {60'd0, y16}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("mid_post_y", {61'd0, y8}, 64'd6);
        check("mid_post_done", {63'd0, done8}, 64'd1);

        // EN toggle takes effect on the next edge only
        en8 = 1'b0;
        #2;
        check("en_hold_y", {61'd0, y8}, 64'd6);
        tick();
        check("en_off_done", {63'd0, done8}, 64'd0);

        // randomized against the reference model
        for (int r = 0; r < 300; r++) begin
            logic [7:0]  a;
            logic [15:0] b;
            a = 8'($urandom) >> $urandom_range(0, 8);
            b = 16'($urandom) >> $urandom_range(0, 16);
            drive(a, ($urandom_range(0, 3) != 0), b, ($urandom_range(0, 3) != 0));
            tick();
            check_sb($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/basic_homework4.md
BASIC_HOMEWORK4 -- requirements
Module: basic_homework4

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter: N_IN, default 8, number of request inputs; legal values are powers of two from 2 to 64.
REQ-003 Parameter: Y_W, default 3, output index width, equal to log2(N_IN).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: IN  input  N_IN  request vector; bit i is request i.
REQ-007 Port: EN  input  1  encoder enable, active-high.
REQ-008 Port: Y  output  Y_W  index of the highest-numbered asserted IN bit, registered.
REQ-009 Port: Done  output  1  valid flag, registered; high when Y holds a real index.

Function
REQ-010 Priority SHALL be highest-index-wins: IN[N_IN-1] has top priority and IN[0] the lowest.
REQ-011 Each rising clk edge SHALL sample IN and EN and update Y/Done; latency SHALL be exactly 1 cycle, with no input register.
REQ-012 With EN=1 and IN≠0, Y SHALL equal the position of the most-significant 1 in IN, and Done SHALL be 1.
REQ-013 With EN=1 and IN=0, Y SHALL be 0 and Done SHALL be 0 (no request).
REQ-014 With EN=0, Y SHALL be 0 and Done SHALL be 0 regardless of IN.
REQ-015 Multiple asserted bits: lower bits SHALL be ignored, e.g. IN=8'b0010_0101 -> Y=5.
REQ-016 IN=0000_0001 SHALL give Y=0 with Done=1; this is distinguishable from no request only via Done.
REQ-017 Outputs SHALL hold their registered value between edges; there is no combinational path from IN or EN to Y or Done.
REQ-018 EN toggling SHALL take effect on the next edge; there is no internal state beyond the output registers.
REQ-019 X/Z on IN while EN=0 SHALL NOT propagate to the outputs.

Reset
REQ-020 With rst_n=0, Y SHALL be 0 and Done SHALL be 0 immediately, independent of clk.
REQ-021 Reset asserted mid-operation SHALL clear the outputs at once; the first edge after rst_n rises SHALL resume normal encoding of the current IN and EN.
REQ-022 Reset deassertion SHALL be assumed synchronous to clk by the surrounding system; the block SHALL NOT contain a reset synchronizer.

Structure
REQ-023 A shared package basic_homework4_pkg SHALL hold the N_IN/Y_W defaults and an Y_W-bit index typedef.
REQ-024 One combinational sub-module, prio_enc, SHALL compute the next index and valid from IN and EN; the top level SHALL add only the output register.
REQ-025 prio_enc SHALL be parameterized by N_IN and SHALL scan from the MSB down, with no hard-coded 8-way case.

Verification
REQ-026 Reset: rst_n=0 with IN=8'hFF, EN=1 -> Y=0, Done=0 with no clock edge required.
REQ-027 Disabled: EN=0 with IN=8'h80 -> after one edge, Y=0, Done=0.
REQ-028 One-hot sweep: EN=1, IN=8'h00,01,02,04,08,10,20,40,80 at one value per cycle -> one cycle later Y=0,0,1,2,3,4,5,6,7 and Done=0,1,1,1,1,1,1,1,1.
REQ-029 Priority: EN=1 with IN=8'b0010_0101 -> Y=5, Done=1; IN=8'b1111_1111 -> Y=7, Done=1.
REQ-030 Reset mid-run: EN=1, IN=8'h40 gives Y=6, Done=1; pulse rst_n low between edges -> Y=0, Done=0 at once; Y=6 again on the first edge after release.
REQ-031 Parameter: N_IN=16, Y_W=4, EN=1, IN=16'h8001 -> Y=15, Done=1.
